// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard / stall controller for the 5-stage core.
// Detects load-use and mult/div-not-ready hazards, drives the PC and IF/ID
// enables, ID/EX bubble and IF/ID flush, and sequences the multi-cycle
// mult/div unit with a saturating count of stalled cycles.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,   // cycles from MD_Start to HI/LO valid (mult)
  parameter int DIV_LAT = 32,  // cycles from MD_Start to HI/LO valid (div)
  parameter int CNT_W   = 16   // width of the saturating stall counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RsAddr,
  input  logic [4:0]       ID_RtAddr,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             ID_IsDiv,
  input  logic             ID_ReadHiLo,
  input  logic             ID_BrTaken,
  input  logic             EX_MemRead,
  input  logic             EX_WriteReg,
  input  logic [4:0]       EX_wAddr,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [5:0]       MUL_CNT  = 6'(MUL_LAT);
  localparam logic [5:0]       DIV_CNT  = 6'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_hz;
  logic stall;
  logic md_issue;

  // Hazard detection: a stall is decided in the same cycle the ID
  // instruction is seen; a load into $0 never creates a dependency.
  always_comb begin
    load_use = EX_MemRead & EX_WriteReg & (|EX_wAddr) &
               ((ID_UsesRs & (EX_wAddr == ID_RsAddr)) |
                (ID_UsesRt & (EX_wAddr == ID_RtAddr)));
    md_hz    = (state_q == MD_WAIT) & (ID_ReadHiLo | ID_MulDiv);
    stall    = load_use | md_hz;
    md_issue = ID_MulDiv & ~stall;
  end

  // State register: FSM state, mult/div down-counter and stall counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: issue moves RUN -> MD_WAIT with the op latency loaded;
  // the final count of 1 marks the cycle at whose end HI/LO is valid.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      RUN: begin
        if (md_issue) begin
          state_d  = MD_WAIT;
          md_cnt_d = ID_IsDiv ? DIV_CNT : MUL_CNT;
        end
      end
      MD_WAIT: begin
        if (md_cnt_q == 6'd1) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase

    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // Outputs: while reset is held the pipeline is frozen with NOPs in
  // IF/ID and ID/EX; otherwise the enables follow the stall decision and
  // a taken branch only flushes once its operands are not stalled.
  always_comb begin
    PC_Write    = 1'b0;
    IFID_Write  = 1'b0;
    IDEX_Bubble = 1'b1;
    IFID_Flush  = 1'b1;
    MD_Start    = 1'b0;
    MD_Busy     = 1'b0;
    if (rst_n) begin
      PC_Write    = ~stall;
      IFID_Write  = ~stall;
      IDEX_Bubble = stall;
      IFID_Flush  = ID_BrTaken & ~stall;
      MD_Start    = md_issue;
      MD_Busy     = (state_q == MD_WAIT);
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus
// randomized traffic, all compared every cycle against a cycle-indexed
// behavioural model. A second instance with a 4-bit counter exercises
// stall-counter saturation on the same stimulus.
module tb_hazard_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_RsAddr, ID_RtAddr, EX_wAddr;
  logic        ID_UsesRs, ID_UsesRt, ID_MulDiv, ID_IsDiv, ID_ReadHiLo, ID_BrTaken;
  logic        EX_MemRead, EX_WriteReg;

  logic             PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Start, MD_Busy;
  logic [CNT_W-1:0] StallCnt;
  logic             s_PC_Write, s_IFID_Write, s_IDEX_Bubble, s_IFID_Flush, s_MD_Start, s_MD_Busy;
  logic [SAT_W-1:0] s_StallCnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv),
    .ID_ReadHiLo(ID_ReadHiLo), .ID_BrTaken(ID_BrTaken),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_wAddr(EX_wAddr),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .StallCnt(StallCnt)
  );

  hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv),
    .ID_ReadHiLo(ID_ReadHiLo), .ID_BrTaken(ID_BrTaken),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_wAddr(EX_wAddr),
    .PC_Write(s_PC_Write), .IFID_Write(s_IFID_Write), .IDEX_Bubble(s_IDEX_Bubble),
    .IFID_Flush(s_IFID_Flush), .MD_Start(s_MD_Start), .MD_Busy(s_MD_Busy),
    .StallCnt(s_StallCnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The mult/div unit is modelled as "busy until cycle md_done": an op
  // issued in cycle c keeps HI/LO unavailable for cycles c+1 .. c+lat.
  initial begin : compare_proc
    int    cyc      = 0;
    int    md_done  = 0;
    longint total   = 0;
    bit    busy, lu, stl, start;
    longint exp_cnt, exp_sat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        md_done = cyc;
        total   = 0;
        check("rst_pc_write",  PC_Write,    0);
        check("rst_ifid_write", IFID_Write, 0);
        check("rst_bubble",    IDEX_Bubble, 1);
        check("rst_flush",     IFID_Flush,  1);
        check("rst_md_start",  MD_Start,    0);
        check("rst_md_busy",   MD_Busy,     0);
        check("rst_stallcnt",  StallCnt,    0);
        check("rst_sat_cnt",   s_StallCnt,  0);
        stl = 0; start = 0;
      end else begin
        busy  = (cyc < md_done);
        lu    = EX_MemRead && EX_WriteReg && (EX_wAddr != 0) &&
                ((ID_UsesRs && EX_wAddr == ID_RsAddr) || (ID_UsesRt && EX_wAddr == ID_RtAddr));
        stl   = lu || (busy && (ID_ReadHiLo || ID_MulDiv));
        start = ID_MulDiv && !stl;
        exp_cnt = (total > 65535) ? 65535 : total;
        exp_sat = (total > 15) ? 15 : total;
        check("pc_write",   PC_Write,    !stl);
        check("ifid_write", IFID_Write,  !stl);
        check("bubble",     IDEX_Bubble, stl);
        check("flush",      IFID_Flush,  ID_BrTaken && !stl);
        check("md_start",   MD_Start,    start);
        check("md_busy",    MD_Busy,     busy);
        check("stallcnt",   StallCnt,    32'(exp_cnt));
        check("sat_cnt",    s_StallCnt,  32'(exp_sat));
        check("sat_pc_write", s_PC_Write, !stl);
      end
      @(posedge clk);
      if (rst_n) begin
        if (stl) total++;
        if (start) md_done = cyc + 1 + (ID_IsDiv ? DIV_LAT : MUL_LAT);
      end else begin
        total   = 0;
        md_done = cyc + 1;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_RsAddr = 0; ID_RtAddr = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_MulDiv = 0; ID_IsDiv = 0; ID_ReadHiLo = 0; ID_BrTaken = 0;
    EX_MemRead = 0; EX_WriteReg = 0; EX_wAddr = 0;
  endtask

  task automatic set_load(input logic [4:0] waddr, input logic wr);
    EX_MemRead = 1; EX_WriteReg = wr; EX_wAddr = waddr;
  endtask

  task automatic do_reset();
    step();
    rst_n = 0;
    idle_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int stalls, busy_cnt, starts, n;
    rst_n = 0;
    idle_inputs();
    #3;
    check("lit_rst_pc_write", PC_Write, 0);
    check("lit_rst_flush",    IFID_Flush, 1);
    check("lit_rst_cnt",      StallCnt, 0);
    step(); step();
    rst_n = 1;

    // load-use on rs: one stall cycle
    step();
    set_load(5'd8, 1); ID_RsAddr = 8; ID_UsesRs = 1;
    #3;
    check("lit_lu_pc_write", PC_Write, 0);
    check("lit_lu_bubble",   IDEX_Bubble, 1);
    step();
    idle_inputs();
    #3;
    check("lit_lu_cnt", StallCnt, 1);
    check("lit_lu_released", PC_Write, 1);

    // load into $0, rt-only match with UsesRt=0, no register write
    step();
    set_load(5'd0, 1); ID_RsAddr = 0; ID_UsesRs = 1;
    #3; check("lit_lu_r0", PC_Write, 1);
    step();
    idle_inputs(); set_load(5'd9, 1); ID_RtAddr = 9; ID_UsesRt = 0; ID_UsesRs = 1; ID_RsAddr = 3;
    #3; check("lit_lu_rt_unused", PC_Write, 1);
    step();
    idle_inputs(); set_load(5'd9, 0); ID_RsAddr = 9; ID_UsesRs = 1;
    #3; check("lit_lu_nowrite", PC_Write, 1);

    // mult then mflo: 4 stalled cycles, issue on the fifth
    step();
    idle_inputs(); ID_MulDiv = 1; ID_IsDiv = 0;
    #3; check("lit_mult_start", MD_Start, 1);
    step();
    idle_inputs(); ID_ReadHiLo = 1;
    stalls = 0; busy_cnt = 0; n = 0;
    #3;
    while (PC_Write == 0 && n < 100) begin
      stalls++; busy_cnt += MD_Busy; n++;
      step(); #3;
    end
    check("lit_mflo_stalls", stalls, MUL_LAT);
    check("lit_mult_busy",   busy_cnt, MUL_LAT);
    check("lit_mflo_busy_after", MD_Busy, 0);

    // div, div back-to-back: second stalls DIV_LAT cycles, two starts total
    step();
    idle_inputs(); ID_MulDiv = 1; ID_IsDiv = 1;
    #3; starts = MD_Start;
    step();
    stalls = 0; n = 0;
    #3;
    while (PC_Write == 0 && n < 100) begin
      stalls++; starts += MD_Start; n++;
      step(); #3;
    end
    starts += MD_Start;
    check("lit_div2_stalls", stalls, DIV_LAT);
    step();
    idle_inputs();
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      #3; starts += MD_Start;
      step();
    end
    check("lit_div_starts", starts, 2);

    // taken branch vs load-use: flush deferred one cycle
    idle_inputs(); set_load(5'd5, 1); ID_RsAddr = 5; ID_UsesRs = 1; ID_BrTaken = 1;
    #3; check("lit_br_lu_flush", IFID_Flush, 0);
    step();
    idle_inputs(); ID_RsAddr = 5; ID_UsesRs = 1; ID_BrTaken = 1;
    #3; check("lit_br_retry_flush", IFID_Flush, 1);

    // reset in the middle of a div
    step();
    idle_inputs(); ID_MulDiv = 1; ID_IsDiv = 1;
    step();
    idle_inputs();
    for (int i = 0; i < DIV_LAT - 10; i++) step();
    #3; check("lit_middiv_busy", MD_Busy, 1);
    step();
    rst_n = 0;
    #1; check("lit_async_busy", MD_Busy, 0);
    check("lit_async_start", MD_Start, 0);
    step();
    rst_n = 1;
    #3; check("lit_after_rst_busy", MD_Busy, 0);

    // saturation of the 4-bit counter
    do_reset();
    set_load(5'd7, 1); ID_RtAddr = 7; ID_UsesRt = 1;
    for (int i = 0; i < 14; i++) step();
    #3; check("lit_sat_14", s_StallCnt, 14);
    step(); #3; check("lit_sat_15", s_StallCnt, 15);
    for (int i = 0; i < 5; i++) step();
    #3; check("lit_sat_hold", s_StallCnt, 15);
    check("lit_wide_cnt", StallCnt, 20);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      rst_n       = ($urandom_range(0, 299) != 0);
      ID_RsAddr   = 5'($urandom_range(0, 3));
      ID_RtAddr   = 5'($urandom_range(0, 3));
      ID_UsesRs   = 1'($urandom_range(0, 1));
      ID_UsesRt   = 1'($urandom_range(0, 1));
      ID_MulDiv   = ($urandom_range(0, 7) == 0);
      ID_IsDiv    = ($urandom_range(0, 3) == 0);
      ID_ReadHiLo = ($urandom_range(0, 3) == 0);
      ID_BrTaken  = ($urandom_range(0, 3) == 0);
      EX_MemRead  = 1'($urandom_range(0, 1));
      EX_WriteReg = ($urandom_range(0, 3) != 0);
      EX_wAddr    = 5'($urandom_range(0, 3));
    end
    step();
    rst_n = 1;
    idle_inputs();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
